// File: rtl/ahb_pkg.sv
// Shared AHB arbiter types: transfer/burst encodings, arbiter FSM states and
// the beat-count load used when a new burst is accepted.
package ahb_pkg;

  localparam int DEFAULT_NUM_MASTERS = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } hburst_t;

  typedef enum logic [1:0] {
    ARB_PARK   = 2'd0,
    ARB_ACTIVE = 2'd1,
    ARB_BURST  = 2'd2,
    ARB_LOCKED = 2'd3
  } arb_state_t;

  // Beats still owed after the first beat of a burst; undefined-length INCR
  // behaves like SINGLE so it can be re-arbitrated on every beat.
  function automatic logic [3:0] burst_rem_load(hburst_t b);
    case (b)
      WRAP4,  INCR4:  return 4'd3;
      WRAP8,  INCR8:  return 4'd7;
      WRAP16, INCR16: return 4'd15;
      default:        return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search: first asserted req after 'last',
// wrapping around and finishing on 'last' itself.
module rr_priority_picker #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] next,
  output logic         found
);

  logic [W-1:0] w_idx;

  always_comb begin
    next  = '0;
    found = 1'b0;
    w_idx = '0;
    for (int i = 1; i <= N; i++) begin
      w_idx = W'((int'(last) + i) % N);
      if (!found && req[w_idx]) begin
        found = 1'b1;
        next  = w_idx;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// Registered round-robin AHB arbiter with fixed-burst and locked-transfer hold.
//   state      | meaning
//   ARB_PARK   | next owner is not requesting (parked)
//   ARB_ACTIVE | owner requesting, rem=0, unlocked
//   ARB_BURST  | fixed burst in progress (rem>0)
//   ARB_LOCKED | owner holds Hlock; bus cannot be re-arbitrated
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS = DEFAULT_NUM_MASTERS
) (
  input  logic                           Hclk,
  input  logic                           Hresetn,
  input  logic [NUM_MASTERS-1:0]         Hbusreq,
  input  logic [NUM_MASTERS-1:0]         Hlock,
  input  logic [1:0]                     Htrans,
  input  logic [2:0]                     Hburst,
  input  logic                           Hready,
  output logic [NUM_MASTERS-1:0]         Hgrant,
  output logic [$clog2(NUM_MASTERS)-1:0] Hmaster,
  output logic [$clog2(NUM_MASTERS)-1:0] Hmaster_data,
  output logic                           Hmastlock
);

  localparam int MW = $clog2(NUM_MASTERS);

  arb_state_t  r_state;
  arb_state_t  w_state_next;
  logic [MW-1:0] r_master;
  logic [MW-1:0] r_master_data;
  logic [3:0]    r_rem;

  logic [3:0]    w_rem_next;
  logic          w_owner_locked;
  logic          w_arb_allowed;
  logic [MW-1:0] w_pick;
  logic          w_found;
  logic [MW-1:0] w_master_next;

  rr_priority_picker #(
    .N (NUM_MASTERS),
    .W (MW)
  ) u_picker (
    .req   (Hbusreq),
    .last  (r_master),
    .next  (w_pick),
    .found (w_found)
  );

  always_comb begin
    w_rem_next = r_rem;
    if (Hready) begin
      unique case (htrans_t'(Htrans))
        NONSEQ:  w_rem_next = burst_rem_load(hburst_t'(Hburst));
        SEQ:     w_rem_next = (r_rem == 4'd0) ? 4'd0 : r_rem - 4'd1;
        default: w_rem_next = r_rem;
      endcase
    end
  end

  assign w_owner_locked = Hlock[r_master];
  // Arbitration looks at rem after this edge's update, so the edge accepting
  // the last beat of a burst is already a handover point.
  assign w_arb_allowed  = Hready && !w_owner_locked && (w_rem_next == 4'd0);
  assign w_master_next  = !w_arb_allowed ? r_master : (w_found ? w_pick : '0);

  always_comb begin
    w_state_next = r_state;
    if (Hready) begin
      if (w_owner_locked)              w_state_next = ARB_LOCKED;
      else if (w_rem_next != 4'd0)     w_state_next = ARB_BURST;
      else if (Hbusreq[w_master_next]) w_state_next = ARB_ACTIVE;
      else                             w_state_next = ARB_PARK;
    end
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_state       <= ARB_PARK;
      r_master      <= '0;
      r_master_data <= '0;
      r_rem         <= 4'd0;
    end else if (Hready) begin
      r_state       <= w_state_next;
      r_master      <= w_master_next;
      r_master_data <= r_master;
      r_rem         <= w_rem_next;
    end
  end

  always_comb begin
    Hgrant           = '0;
    Hgrant[r_master] = 1'b1;
  end

  assign Hmaster      = r_master;
  assign Hmaster_data = r_master_data;
  // LOCKED is entered exactly when the owner's Hlock is seen on a ready edge.
  assign Hmastlock    = (r_state == ARB_LOCKED);

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter (4 masters): a cycle-level reference model
// is compared every cycle, plus literal expectations for each scenario.
module tb_ahb_arbiter;
  import ahb_pkg::*;

  localparam int NM = 4;

  logic          Hclk = 1'b0;
  logic          Hresetn = 1'b1;
  logic [NM-1:0] Hbusreq = '0;
  logic [NM-1:0] Hlock = '0;
  logic [1:0]    Htrans = 2'd0;
  logic [2:0]    Hburst = 3'd0;
  logic          Hready = 1'b1;
  logic [NM-1:0] Hgrant;
  logic [1:0]    Hmaster;
  logic [1:0]    Hmaster_data;
  logic          Hmastlock;

  int checks = 0;
  int failures = 0;

  int m_owner = 0;
  int m_data = 0;
  int m_lock = 0;
  int m_rem = 0;

  ahb_arbiter #(.NUM_MASTERS(NM)) dut (
    .Hclk         (Hclk),
    .Hresetn      (Hresetn),
    .Hbusreq      (Hbusreq),
    .Hlock        (Hlock),
    .Htrans       (Htrans),
    .Hburst       (Hburst),
    .Hready       (Hready),
    .Hgrant       (Hgrant),
    .Hmaster      (Hmaster),
    .Hmaster_data (Hmaster_data),
    .Hmastlock    (Hmastlock)
  );

  initial forever #5 Hclk = ~Hclk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit bit_of(input logic [NM-1:0] v, input int i);
    return ((v >> i) & 1) != 0;
  endfunction

  function automatic int burst_len(input logic [2:0] b);
    case (b)
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      3'd6, 3'd7: return 16;
      default:    return 1;
    endcase
  endfunction

  function automatic int rem_after(input int rem, input logic [1:0] t, input logic [2:0] b);
    if (t == 2'd2) return burst_len(b) - 1;
    if (t == 2'd3) return (rem > 0) ? rem - 1 : 0;
    return rem;
  endfunction

  function automatic int rr_next(input int owner, input logic [NM-1:0] req);
    for (int k = 1; k <= NM; k++)
      if (bit_of(req, (owner + k) % NM)) return (owner + k) % NM;
    return 0;
  endfunction

  always @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      m_owner <= 0;
      m_data  <= 0;
      m_lock  <= 0;
      m_rem   <= 0;
    end else if (Hready) begin
      m_rem  <= rem_after(m_rem, Htrans, Hburst);
      m_data <= m_owner;
      m_lock <= bit_of(Hlock, m_owner) ? 1 : 0;
      if (!bit_of(Hlock, m_owner) && rem_after(m_rem, Htrans, Hburst) == 0)
        m_owner <= rr_next(m_owner, Hbusreq);
    end
  end

  always @(negedge Hclk) begin
    check("model_hmaster", int'(Hmaster), m_owner);
    check("model_hmaster_data", int'(Hmaster_data), m_data);
    check("model_hmastlock", int'(Hmastlock), m_lock);
    check("model_hgrant", int'(Hgrant), 1 << m_owner);
  end

  task automatic step();
    @(negedge Hclk);
  endtask

  task automatic drive(input logic [NM-1:0] req, input logic [NM-1:0] lck,
                       input logic [1:0] t, input logic [2:0] b, input logic rdy);
    Hbusreq = req;
    Hlock   = lck;
    Htrans  = t;
    Hburst  = b;
    Hready  = rdy;
  endtask

  int exp_m[5] = '{1, 2, 3, 0, 1};
  int exp_d[5] = '{0, 1, 2, 3, 0};
  int n;

  initial begin
    #1 Hresetn = 1'b0;
    step();
    check("reset_hmaster", int'(Hmaster), 0);
    check("reset_hgrant", int'(Hgrant), 4'b0001);
    check("reset_hmastlock", int'(Hmastlock), 0);
    step();
    Hresetn = 1'b1;
    step();
    step();
    check("idle_hmaster", int'(Hmaster), 0);
    check("idle_hgrant", int'(Hgrant), 4'b0001);
    check("idle_hmastlock", int'(Hmastlock), 0);

    // all masters requesting single transfers: plain rotation
    drive(4'b1111, 4'b0000, NONSEQ, SINGLE, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("rr_hmaster", int'(Hmaster), exp_m[i]);
      check("rr_hmaster_data", int'(Hmaster_data), exp_d[i]);
    end

    drive(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1);
    step();
    check("park_master0", int'(Hmaster), 0);

    drive(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1);
    step();
    check("grant_m2", int'(Hmaster), 2);
    step();
    check("retain_sole_owner", int'(Hmaster), 2);

    // INCR4 from master 2 while master 1 waits
    drive(4'b0110, 4'b0000, NONSEQ, INCR4, 1'b1);
    step();
    check("incr4_beat1", int'(Hmaster), 2);
    drive(4'b0110, 4'b0000, SEQ, INCR4, 1'b1);
    step();
    check("incr4_beat2", int'(Hmaster), 2);
    step();
    check("incr4_beat3", int'(Hmaster), 2);
    step();
    check("incr4_handover", int'(Hmaster), 1);

    // same burst with beat 2 stalled three cycles
    drive(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1);
    step();
    check("stall_grant_m2", int'(Hmaster), 2);
    drive(4'b0110, 4'b0000, NONSEQ, INCR4, 1'b1);
    step();
    n = 1;
    drive(4'b0110, 4'b0000, SEQ, INCR4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      n++;
      check("stall_hold_master", int'(Hmaster), 2);
      check("stall_hold_data", int'(Hmaster_data), 2);
    end
    Hready = 1'b1;
    while (int'(Hmaster) == 2 && n < 12) begin
      step();
      n++;
    end
    check("stall_handover_cycles", n, 7);
    check("stall_handover_master", int'(Hmaster), 1);

    // locked sequence from master 3
    drive(4'b1000, 4'b0000, IDLE, SINGLE, 1'b1);
    step();
    check("lock_grant_m3", int'(Hmaster), 3);
    drive(4'b1111, 4'b1000, NONSEQ, SINGLE, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("lock_hold_master", int'(Hmaster), 3);
      check("lock_hmastlock", int'(Hmastlock), 1);
    end
    Hlock = 4'b0000;
    step();
    check("unlock_handover", int'(Hmaster), 0);
    check("unlock_hmastlock", int'(Hmastlock), 0);

    // reset pulse in the middle of an INCR8 from master 1
    drive(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1);
    step();
    check("incr8_grant_m1", int'(Hmaster), 1);
    drive(4'b0011, 4'b0000, NONSEQ, INCR8, 1'b1);
    step();
    drive(4'b0011, 4'b0000, SEQ, INCR8, 1'b1);
    step();
    step();
    check("incr8_pre_reset", int'(Hmaster), 1);
    #2 Hresetn = 1'b0;
    #1;
    check("async_rst_hmaster", int'(Hmaster), 0);
    check("async_rst_hmaster_data", int'(Hmaster_data), 0);
    check("async_rst_hgrant", int'(Hgrant), 4'b0001);
    check("async_rst_hmastlock", int'(Hmastlock), 0);
    step();
    Hresetn = 1'b1;
    drive(4'b0011, 4'b0000, IDLE, SINGLE, 1'b1);
    step();
    check("post_reset_arbitrate", int'(Hmaster), 1);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
